// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the pipelined MIPS core. It owns the program
// counter, presents it to the combinational instruction memory, and captures
// the returned word together with PC+4 in the IF/ID pipeline register. The
// stage honours load-use stalls from the hazard unit and PC redirects (taken
// branch, j/jal, jr) from later stages, and inserts a NOP bubble on redirect.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   BUBBLE         instruction word written to IF/ID on a bubble (NOP)
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high reset
//   stall_i        hold PC and IF/ID for this edge
//   redirect_i     load redirect_pc_i into PC and squash the current fetch
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_addr_o    fetch address (equals PC)
//   imem_instr_i   instruction returned combinationally for imem_addr_o
//   ifid_instr_o   IF/ID instruction
//   ifid_pc4_o     IF/ID PC+4
//   ifid_valid_o   1 = real instruction, 0 = bubble
//   fetch_count_o  number of instructions accepted into IF/ID (debug)

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [15:0] fetch_count_o
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_aligned;
  logic [31:0] w_reset_aligned;

  // Modulo-2^32 increment: 32'hFFFF_FFFC rolls over to zero.
  assign w_pc_plus4 = r_pc + 32'd4;

  // The PC is kept word aligned at all times, so misaligned redirect targets
  // (and a misaligned RESET_PC override) are silently rounded down.
  assign w_redirect_aligned = {redirect_pc_i[31:2], 2'b00};
  assign w_reset_aligned    = {RESET_PC[31:2], 2'b00};

  // Priority: reset > redirect > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= w_reset_aligned;
      r_instr       <= BUBBLE;
      r_pc4         <= 32'd0;
      r_valid       <= 1'b0;
      r_fetch_count <= 16'd0;
    end else if (redirect_i) begin
      // The word currently being fetched belongs to the wrong path; replace
      // it with a bubble. The fetch counter only counts accepted words.
      r_pc    <= w_redirect_aligned;
      r_instr <= BUBBLE;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_pc          <= w_pc_plus4;
      r_instr       <= imem_instr_i;
      r_pc4         <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign imem_addr_o   = r_pc;
  assign ifid_instr_o  = r_instr;
  assign ifid_pc4_o    = r_pc4;
  assign ifid_valid_o  = r_valid;
  assign fetch_count_o = r_fetch_count;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction plus PC+4 into the IF/ID pipeline register. It sits directly upstream of the instruction memory and feeds the decode stage. It handles load-use stalls from the hazard unit and PC redirects (taken branch, `j`/`jal`, `jr`) from later stages, inserting bubbles as required.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `BUBBLE`, default 32'h0000_0000: instruction word placed in IF/ID on a bubble; this is the NOP, `sll $0,$0,0`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall_i`  in  1: hazard-unit stall; hold PC and IF/ID.
- `redirect_i`  in  1: take `redirect_pc_i` as the next PC and squash the instruction being fetched.
- `redirect_pc_i`  in  32: redirect target.
- `imem_addr_o`  out  32: fetch address to instruction memory, which indexes with `Address[9:2]`.
- `imem_instr_i`  in  32: instruction returned combinationally for `imem_addr_o`.
- `ifid_instr_o`  out  32: IF/ID instruction.
- `ifid_pc4_o`  out  32: IF/ID PC+4. Decode uses it for branch offsets and the `jal` link value.
- `ifid_valid_o`  out  1: 1 = real instruction, 0 = bubble.
- `fetch_count_o`  out  16: count of instructions accepted into IF/ID. Debug only.

## Operation
- State consists of `pc`[31:0], the IF/ID register (`instr`, `pc4`, `valid`), and `fetch_count`[15:0].
- `imem_addr_o = pc` combinationally. `pc[1:0]` is always 2'b00.
- Each rising edge applies exactly one case, in this priority order:
  1. `reset`: set `pc = RESET_PC`, `instr = BUBBLE`, `pc4 = 0`, `valid = 0`, `fetch_count = 0`.
  2. `redirect_i`: set `pc = {redirect_pc_i[31:2], 2'b00}`, `instr = BUBBLE`, `pc4 = 0`, `valid = 0`. `fetch_count` holds. Redirect overrides `stall_i`.
  3. `stall_i`: `pc`, `instr`, `pc4`, `valid` and `fetch_count` all hold.
  4. Normal: set `pc = pc + 4`, `instr = imem_instr_i`, `pc4 = pc + 4`, `valid = 1`, `fetch_count = fetch_count + 1`.
- Arithmetic:
  - `pc + 4` is unsigned modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
  - `fetch_count` wraps from 16'hFFFF to 0.
- Misaligned redirect targets are silently word-aligned. No exception is raised.
- Instructions are not interpreted, including the custom 0x3F display opcode. They pass through unchanged.
- Outputs are direct register values, with no combinational path from inputs except `imem_addr_o` from `pc`.

## Timing
- Reset values:
  - `imem_addr_o = RESET_PC`
  - `ifid_instr_o = BUBBLE`
  - `ifid_pc4_o = 0`
  - `ifid_valid_o = 0`
  - `fetch_count_o = 0`
- The first real instruction appears in IF/ID one edge after `reset` deasserts, provided there is no stall or redirect.
- Fetch latency: an instruction addressed in cycle n appears on `ifid_*` after edge n→n+1.
- Redirect penalty: `redirect_i` in cycle n squashes one fetch. The target address is on `imem_addr_o` in cycle n+1. The target instruction is valid in IF/ID after edge n+1→n+2.
- Stall: while `stall_i` is high, `imem_addr_o` and all IF/ID outputs are stable. Fetch resumes at the same PC on the first cycle without the stall.
- `reset` asserted mid-operation overrides redirect and stall on that same edge. The pipeline restarts from `RESET_PC` with no partial state retained.
- `redirect_i` and `stall_i` are sampled only at the clock edge. Glitches between edges have no effect.

## Test plan
- Reset and sequential fetch:
  - Stimulus: hold `reset` for 2 cycles, release, and model memory with word 0 = 32'h2004_0005 and word 1 = 32'h0000_1026.
  - Required: during reset, addresses are 0 and `valid = 0`. Then IF/ID = (32'h2004_0005, pc4 = 4, valid = 1), followed by (32'h0000_1026, pc4 = 8). `fetch_count` reads 1, then 2.
- Stall hold:
  - Stimulus: assert `stall_i` for 3 cycles while `pc = 0x0C`.
  - Required: `imem_addr_o` stays at 0x0C and the IF/ID outputs and `fetch_count` are unchanged. One cycle after release, IF/ID holds word 3 with pc4 = 0x10.
- Redirect (jal) plus simultaneous stall:
  - Stimulus: assert `redirect_i` and `stall_i` together with `redirect_pc_i = 0x20`.
  - Required: the next cycle shows `imem_addr_o = 0x20` and `ifid_valid_o = 0`. The cycle after shows IF/ID = word 8 with pc4 = 0x24 and `valid = 1`.
- Misaligned redirect and backward branch:
  - Stimulus: apply `redirect_pc_i = 0x23`, then `redirect_pc_i = 0x0C`.
  - Required: `imem_addr_o` becomes 0x20, then 0x0C. Each redirect produces exactly one bubble.
- PC wrap:
  - Stimulus: redirect to 0xFFFF_FFFC and run 2 unstalled cycles.
  - Required: IF/ID pc4 = 0x0000_0000 and the next `imem_addr_o` = 0x0000_0000.
- Reset mid-operation:
  - Stimulus: assert `reset` together with `redirect_i` while `pc = 0x40` and `fetch_count = 10`.
  - Required: after the edge, `pc = RESET_PC`, `valid = 0`, `fetch_count = 0`.
